uart_tx_buffered: RTL

Buffered UART transmitter. It sits on the response path of the command interface, downstream of the command FSM's `txData`/`txDataWr` outputs. Single-cycle byte writes are queued in a small FIFO and serialized as 8N1 frames on the host serial line. It lets the command FSM emit echo, ACK (`*`), error (`!`) and status bytes on back-to-back cycles without handshaking.

---
 rtl/fda_uart_pkg.sv | 19 +
 rtl/uart_tx_buffered_if.sv | 28 ++
 rtl/sync_fifo_byte.sv | 76 +++++++
 rtl/uart_tx_buffered.sv | 124 ++++++++++++
 4 files changed

// File: rtl/fda_uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package fda_uart_pkg;

    // Serializer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // 100 MHz system clock / 115200 baud
    localparam int unsigned CLKS_PER_BIT_DEF = 868;

    // Start + 8 data + stop
    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = 8;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte-write / status bundle between the command FSM and the buffered transmitter.
interface uart_tx_buffered_if #(
    parameter int unsigned FIFO_AW = 4
) ();

    logic [7:0]       txData;
    logic             txDataWr;
    logic             clrOverflow;
    logic             tx;
    logic             txBusy;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [FIFO_AW:0] fifoCount;
    logic             overflow;

    // Producer side: command FSM (or bench)
    modport master (
        output txData, txDataWr, clrOverflow,
        input  tx, txBusy, fifoFull, fifoEmpty, fifoCount, overflow
    );

    // Transmitter side
    modport slave (
        input  txData, txDataWr, clrOverflow,
        output tx, txBusy, fifoFull, fifoEmpty, fifoCount, overflow
    );

endinterface

// File: rtl/sync_fifo_byte.sv
// 8-bit synchronous first-word-fall-through FIFO with registered flags.
module sync_fifo_byte #(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr,
    input  logic [7:0]    i_wdata,
    input  logic          i_rd,
    output logic [7:0]    o_rdata_c,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;

    logic          w_wr_ok;
    logic          w_rd_ok;
    logic [AW:0]   w_count_nxt;

    // A write while full is dropped regardless of a simultaneous pop
    assign w_wr_ok = i_wr && !r_full;
    assign w_rd_ok = i_rd && !r_empty;

    // Next occupancy: write-only +1, pop-only -1, both or neither unchanged
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_ok && !w_rd_ok) begin
            w_count_nxt = r_count + (AW+1)'(1);
        end else if (!w_wr_ok && w_rd_ok) begin
            w_count_nxt = r_count - (AW+1)'(1);
        end
    end

    // Storage array, no reset needed since pointers define validity
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers, count and registered flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_rdata_c = r_mem[r_rptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_count   = r_count;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a serializer FSM.
module uart_tx_buffered
    import fda_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_buffered_if.slave    bus
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_e         r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              r_overflow;

    logic              w_pop;
    logic              w_baud_done;
    logic [7:0]        w_head;
    logic              w_full;
    logic              w_empty;
    logic [FIFO_AW:0]  w_count;

    sync_fifo_byte #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr      (bus.txDataWr),
        .i_wdata   (bus.txData),
        .i_rd      (w_pop),
        .o_rdata_c (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    assign w_baud_done = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

    // Serializer FSM with baud/bit counters; tx registered from current state and shift reg
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_START: r_tx <= 1'b0;
                S_DATA:  r_tx <= r_shift[0];
                default: r_tx <= 1'b1;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_bit   <= '0;
                        r_baud  <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow: a dropped write beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (bus.txDataWr && w_full) begin
            r_overflow <= 1'b1;
        end else if (bus.clrOverflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.tx        = r_tx;
    assign bus.txBusy    = !w_empty || (r_state != S_IDLE);
    assign bus.fifoFull  = w_full;
    assign bus.fifoEmpty = w_empty;
    assign bus.fifoCount = w_count;
    assign bus.overflow  = r_overflow;

endmodule
